// File: rtl/traffic_phase_ctrl.sv
// N-phase intersection controller: prescaled green/yellow/all-red timing, round-robin demand skipping, 2-bit lamp code per phase.
// Lights decode combinationally from registered state; no backpressure. TRAFFIC_PREEMPT_EN adds emergency preemption.
module traffic_phase_ctrl #(
    parameter int NUM_PHASES   = 4,
    parameter int PHASE_W      = $clog2(NUM_PHASES),
    parameter int TICK_DIV     = 1,
    parameter int GREEN_TICKS  = 8,
    parameter int YELLOW_TICKS = 3,
    parameter int CLEAR_TICKS  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_PHASES-1:0]   req,
`ifdef TRAFFIC_PREEMPT_EN
    input  logic                    preempt,
    input  logic [PHASE_W-1:0]      preempt_phase,
    output logic                    preempt_active,
`endif
    output logic [2*NUM_PHASES-1:0] light,
    output logic [PHASE_W-1:0]      phase,
    output logic [1:0]              state,
    output logic                    tick
);

    localparam int MAX_GY    = (GREEN_TICKS > YELLOW_TICKS) ? GREEN_TICKS : YELLOW_TICKS;
    localparam int MAX_TICKS = (MAX_GY > CLEAR_TICKS) ? MAX_GY : CLEAR_TICKS;
    localparam int TW        = $clog2(MAX_TICKS + 1);
    localparam int CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [TW-1:0]      G_LOAD   = TW'(GREEN_TICKS - 1);
    localparam logic [TW-1:0]      Y_LOAD   = TW'(YELLOW_TICKS - 1);
    localparam logic [TW-1:0]      C_LOAD   = TW'(CLEAR_TICKS - 1);
    localparam logic [CW-1:0]      CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [PHASE_W-1:0] LAST_PH  = PHASE_W'(NUM_PHASES - 1);

    localparam logic [1:0] LT_GREEN  = 2'b01;
    localparam logic [1:0] LT_YELLOW = 2'b10;

    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_CLEAR  = 2'd2
    } st_t;

    st_t                   cur_st;
    st_t                   nxt_st;
    logic [TW-1:0]         timer;
    logic [TW-1:0]         nxt_tmr;
    logic [PHASE_W-1:0]    nxt_ph;
    logic [PHASE_W-1:0]    rr_ph;
    logic [PHASE_W-1:0]    cand;
    logic                  found;
    logic [CW-1:0]         cnt;
    logic [NUM_PHASES-1:0] pending;
    logic [NUM_PHASES-1:0] clr;
    logic                  green_entry;
    logic                  pre_vld;
    logic [PHASE_W-1:0]    pre_ph;

`ifdef TRAFFIC_PREEMPT_EN
    // Out-of-range preempt targets are treated as no request at all.
    assign pre_vld        = preempt & (int'(preempt_phase) < NUM_PHASES);
    assign pre_ph         = preempt_phase;
    assign preempt_active = pre_vld & (cur_st == ST_GREEN) & (phase == preempt_phase);
`else
    assign pre_vld = 1'b0;
    assign pre_ph  = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Suppressed while rst is high so nothing downstream sees a tick in the reset cycle.
    assign tick = ~rst & (cnt == CNT_LAST);

    // Round-robin search starting just after the served phase and ending on it.
    always_comb begin
        rr_ph = (phase == LAST_PH) ? '0 : phase + PHASE_W'(1);
        cand  = phase;
        found = 1'b0;
        for (int k = 0; k < NUM_PHASES; k++) begin
            cand = (cand == LAST_PH) ? '0 : cand + PHASE_W'(1);
            if (!found && pending[cand]) begin
                found = 1'b1;
                rr_ph = cand;
            end
        end
    end

    always_comb begin
        nxt_st  = cur_st;
        nxt_tmr = timer;
        nxt_ph  = phase;
        case (cur_st)
            ST_GREEN: begin
                if (pre_vld && (phase == pre_ph)) begin
                    nxt_tmr = G_LOAD;
                end else if (pre_vld) begin
                    nxt_st  = ST_YELLOW;
                    nxt_tmr = Y_LOAD;
                end else if (tick) begin
                    if (timer == '0) begin
                        nxt_st  = ST_YELLOW;
                        nxt_tmr = Y_LOAD;
                    end else begin
                        nxt_tmr = timer - TW'(1);
                    end
                end
            end
            ST_YELLOW: begin
                if (tick) begin
                    if (timer == '0) begin
                        nxt_st  = ST_CLEAR;
                        nxt_tmr = C_LOAD;
                    end else begin
                        nxt_tmr = timer - TW'(1);
                    end
                end
            end
            ST_CLEAR: begin
                if (tick) begin
                    if (timer == '0) begin
                        nxt_st  = ST_GREEN;
                        nxt_tmr = G_LOAD;
                        nxt_ph  = pre_vld ? pre_ph : rr_ph;
                    end else begin
                        nxt_tmr = timer - TW'(1);
                    end
                end
            end
            default: begin
                nxt_st  = ST_CLEAR;
                nxt_tmr = C_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_st      <= ST_CLEAR;
            timer       <= C_LOAD;
            phase       <= LAST_PH;
            green_entry <= 1'b0;
        end else begin
            cur_st      <= nxt_st;
            timer       <= nxt_tmr;
            phase       <= nxt_ph;
            green_entry <= (nxt_st == ST_GREEN) && (cur_st != ST_GREEN);
        end
    end

    // Demand of the phase just given green is retired in its first green cycle only.
    always_comb begin
        clr = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            clr[i] = green_entry && (phase == PHASE_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (pending | req) & ~clr;
        end
    end

    always_comb begin
        light = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (phase == PHASE_W'(i)) begin
                if (cur_st == ST_GREEN) begin
                    light[2*i +: 2] = LT_GREEN;
                end else if (cur_st == ST_YELLOW) begin
                    light[2*i +: 2] = LT_YELLOW;
                end
            end
        end
    end

    assign state = cur_st;

endmodule
